// File: rtl/hci_bank_responder_pkg.sv
// hci_bank_responder_pkg: shared constants and the response record for the HCI bank responder.
package hci_bank_responder_pkg;
  localparam int HCI_BANK_RESP_DEPTH_MIN = 2;
  localparam int HCI_DW = 32;
  localparam int HCI_IW = 8;
  localparam int HCI_UW = 1;
  typedef struct packed {
    logic [HCI_DW-1:0] data;
    logic [HCI_IW-1:0] id;
    logic [HCI_UW-1:0] user;
    logic              opc;
  } hci_bank_resp_t;
endpackage

// File: rtl/hci_bank_resp_fifo.sv
// hci_bank_resp_fifo: DEPTH-entry register FIFO with show-ahead head, flush and occupancy count.
module hci_bank_resp_fifo
  import hci_bank_responder_pkg::*;
#(
  parameter int W     = $bits(hci_bank_resp_t),
  parameter int DEPTH = HCI_BANK_RESP_DEPTH_MIN,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] cnt_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push_i) mem_d[wp_q] = data_i;
    wp_d  = flush_i ? '0 : push_i ? ((wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + 1'b1) : wp_q;
    rp_d  = flush_i ? '0 : pop_i  ? ((rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + 1'b1) : rp_q;
    cnt_d = flush_i ? '0 : cnt_q + CW'(push_i) - CW'(pop_i);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  assign data_o  = mem_q[rp_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign cnt_o   = cnt_q;
endmodule

// File: rtl/hci_bank_responder.sv
// hci_bank_responder: HCI target driving a 1-cycle SRAM, buffering responses under credit-based grant.
// Define HCI_BANK_RESPONDER_PERF_EN to add saturating grant-stall and response-stall counters.
module hci_bank_responder
  import hci_bank_responder_pkg::*;
#(
  parameter int DW      = HCI_DW,
  parameter int AW      = 32,
  parameter int IW      = HCI_IW,
  parameter int UW      = HCI_UW,
  parameter int BANK_AW = 10,
  parameter int DEPTH   = HCI_BANK_RESP_DEPTH_MIN
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               req_i,
  output logic               gnt_o,
  input  logic [AW-1:0]      add_i,
  input  logic               wen_i,
  input  logic [DW/8-1:0]    be_i,
  input  logic [DW-1:0]      data_i,
  input  logic [IW-1:0]      id_i,
  input  logic [UW-1:0]      user_i,
  output logic               r_valid_o,
  input  logic               r_ready_i,
  output logic [DW-1:0]      r_data_o,
  output logic [IW-1:0]      r_id_o,
  output logic [UW-1:0]      r_user_o,
  output logic               r_opc_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [BANK_AW-1:0] mem_add_o,
  output logic [DW/8-1:0]    mem_be_o,
  output logic [DW-1:0]      mem_wdata_o,
  input  logic [DW-1:0]      mem_rdata_i
`ifdef HCI_BANK_RESPONDER_PERF_EN
  ,
  output logic [31:0]        perf_gnt_stall_o,
  output logic [31:0]        perf_r_stall_o
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic [UW-1:0] user;
    logic          opc;
  } resp_t;
  logic          hs, push, pop, fifo_empty, fifo_full, unused_add;
  logic [CW-1:0] fifo_cnt;
  logic          s1_v_q, s1_v_d, s1_opc_q, s1_opc_d;
  logic [IW-1:0] s1_id_q, s1_id_d;
  logic [UW-1:0] s1_user_q, s1_user_d;
  resp_t         ft_resp, head, resp;
  assign unused_add = ^{add_i[AW-1:BANK_AW+2], add_i[1:0]};
  // Every in-flight or buffered response holds a slot, so a grant is only given when one is free.
  assign gnt_o = req_i & ~clear_i & (int'(fifo_cnt) + int'(s1_v_q) < DEPTH);
  assign hs    = req_i & gnt_o;
  always_comb begin
    mem_req_o    = hs;
    mem_we_o     = hs & ~wen_i;
    mem_add_o    = hs ? add_i[BANK_AW+1:2] : '0;
    mem_be_o     = hs ? be_i : '0;
    mem_wdata_o  = hs ? data_i : '0;
    s1_v_d       = hs;
    s1_id_d      = hs ? id_i : s1_id_q;
    s1_user_d    = hs ? user_i : s1_user_q;
    s1_opc_d     = hs ? wen_i : s1_opc_q;
    ft_resp.data = s1_opc_q ? mem_rdata_i : '0;
    ft_resp.id   = s1_id_q;
    ft_resp.user = s1_user_q;
    ft_resp.opc  = s1_opc_q;
    resp         = fifo_empty ? ft_resp : head;
    r_valid_o    = s1_v_q | ~fifo_empty;
    pop          = ~fifo_empty & r_ready_i;
    // An S1 response not consumed by fall-through is captured so it stays stable until accepted.
    push         = s1_v_q & ~fifo_full & ~(fifo_empty & r_ready_i);
  end
  assign {r_data_o, r_id_o, r_user_o, r_opc_o} = resp;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_v_q    <= 1'b0;
      s1_id_q   <= '0;
      s1_user_q <= '0;
      s1_opc_q  <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_id_q   <= s1_id_d;
      s1_user_q <= s1_user_d;
      s1_opc_q  <= s1_opc_d;
    end
  end
  hci_bank_resp_fifo #(.W($bits(resp_t)), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clear_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (ft_resp),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .cnt_o   (fifo_cnt)
  );
`ifdef HCI_BANK_RESPONDER_PERF_EN
  logic [31:0] perf_gnt_q, perf_gnt_d, perf_r_q, perf_r_d;
  always_comb begin
    perf_gnt_d = clear_i ? '0 : perf_gnt_q + 32'(req_i & ~gnt_o & ~&perf_gnt_q);
    perf_r_d   = clear_i ? '0 : perf_r_q + 32'(r_valid_o & ~r_ready_i & ~&perf_r_q);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_gnt_q <= '0;
      perf_r_q   <= '0;
    end else begin
      perf_gnt_q <= perf_gnt_d;
      perf_r_q   <= perf_r_d;
    end
  end
  assign perf_gnt_stall_o = perf_gnt_q;
  assign perf_r_stall_o   = perf_r_q;
`endif
endmodule

// File: tb/tb_hci_bank_responder.sv
// tb_hci_bank_responder: directed and random stimulus against a queue scoreboard and word-array memory model.
module tb_hci_bank_responder;
  localparam int DEPTH = 2;
  logic        clk_i = 0, rst_ni = 0, clear_i = 0, req_i = 0, wen_i = 1, r_ready_i = 0;
  logic [31:0] add_i = 0, data_i = 0, mem_rdata_i = 0;
  logic [3:0]  be_i = 0;
  logic [7:0]  id_i = 0;
  logic [0:0]  user_i = 0;
  logic        gnt_o, r_valid_o, r_opc_o, mem_req_o, mem_we_o;
  logic [31:0] r_data_o, mem_wdata_o;
  logic [7:0]  r_id_o;
  logic [0:0]  r_user_o;
  logic [9:0]  mem_add_o;
  logic [3:0]  mem_be_o;
`ifdef HCI_BANK_RESPONDER_PERF_EN
  logic [31:0] perf_gnt_stall_o, perf_r_stall_o;
`endif
  int          n_cmp = 0, n_fail = 0, granted = 0, accepted = 0, gcount;
  logic        hs_prev = 0, stall_prev = 0, last_gnt;
  logic [41:0] held;
  logic [31:0] sram [1024];
  logic [31:0] ref_mem [1024];
  logic [41:0] q [$];

  hci_bank_responder dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .req_i(req_i), .gnt_o(gnt_o),
    .add_i(add_i), .wen_i(wen_i), .be_i(be_i), .data_i(data_i), .id_i(id_i), .user_i(user_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o), .r_id_o(r_id_o),
    .r_user_o(r_user_o), .r_opc_o(r_opc_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_add_o(mem_add_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
`ifdef HCI_BANK_RESPONDER_PERF_EN
    , .perf_gnt_stall_o(perf_gnt_stall_o), .perf_r_stall_o(perf_r_stall_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk_i)
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++) if (mem_be_o[b]) sram[mem_add_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata_i <= sram[mem_add_o];
      end
    end

  // Request side: predicts grants from outstanding count and queues the expected response.
  always @(negedge clk_i) begin
    int w;
    if (!rst_ni || clear_i) begin
      q.delete();
      granted <= accepted;
      hs_prev <= 1'b0;
      if (rst_ni) chk("gnt_during_clear", gnt_o, 0);
    end else begin
      chk("gnt", gnt_o, req_i && (granted - accepted < DEPTH));
      hs_prev <= req_i & gnt_o;
      if (req_i && gnt_o) begin
        w = (add_i >> 2) % 1024;
        chk("mem_cmd", {mem_req_o, mem_we_o, mem_add_o, mem_be_o, mem_wdata_o},
            {1'b1, ~wen_i, 10'(w), be_i, data_i});
        if (wen_i) q.push_back({ref_mem[w], id_i, user_i, 1'b1});
        else begin
          for (int b = 0; b < 4; b++) if (be_i[b]) ref_mem[w][8*b +: 8] = data_i[8*b +: 8];
          q.push_back({32'h0, id_i, user_i, 1'b0});
        end
        granted <= granted + 1;
      end else chk("mem_idle", mem_req_o, 0);
    end
  end

  // Response side: pops the scoreboard on each accepted response.
  always @(negedge clk_i) begin
    if (!rst_ni || clear_i) stall_prev = 1'b0;
    else begin
      if (stall_prev) chk("stable", {r_valid_o, r_data_o, r_id_o, r_user_o, r_opc_o}, {1'b1, held});
      if (hs_prev) chk("latency", r_valid_o, 1);
      if (r_valid_o && r_ready_i) begin
        if (q.size() == 0) chk("unexpected_resp", 1, 0);
        else chk("resp", {r_data_o, r_id_o, r_user_o, r_opc_o}, q.pop_front());
        accepted <= accepted + 1;
      end
      stall_prev = r_valid_o & ~r_ready_i;
      held = {r_data_o, r_id_o, r_user_o, r_opc_o};
    end
  end

  task automatic issue(input logic rq, input logic wn, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic [7:0] id, input logic rr, input logic clr = 0);
    req_i = rq; wen_i = wn; add_i = a; be_i = b; data_i = d; id_i = id; r_ready_i = rr; clear_i = clr;
    @(negedge clk_i);
    last_gnt = gnt_o;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input logic rr, input int n);
    for (int i = 0; i < n; i++) issue(0, 1, 0, 0, 0, 0, rr);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram[i] = 32'(i * 3);
      ref_mem[i] = 32'(i * 3);
    end
    sram[16] = 32'h1122_3344;
    ref_mem[16] = 32'h1122_3344;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_outputs", {r_valid_o, gnt_o, mem_req_o, r_data_o, r_id_o, r_opc_o, mem_add_o}, 0);
    rst_ni = 1;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 8; i++) begin
      issue(1, 1, 32'(i * 4), 4'hF, 0, 8'(i), 1);
      chk("b2b_gnt", last_gnt, 1);
    end
    issue(1, 0, 32'h40, 4'b0101, 32'hAABB_CCDD, 8'h20, 1);
    issue(1, 1, 32'h40, 4'hF, 0, 8'h21, 1);
    idle(1, 2);
    chk("rmw_model", ref_mem[16], 32'h11BB_33DD);
    gcount = 0;
    for (int i = 0; i < 5; i++) begin
      issue(1, 1, 32'(4 * i + 8), 4'hF, 0, 8'(8'h30 + i), 0);
      gcount += int'(last_gnt);
    end
    chk("stall_grants", gcount, DEPTH);
    issue(1, 1, 32'h100, 4'hF, 0, 8'h40, 1);
    chk("gnt_at_first_pop", last_gnt, 0);
    issue(1, 1, 32'h104, 4'hF, 0, 8'h41, 1);
    chk("gnt_after_pop", last_gnt, 1);
    idle(1, 4);
    issue(1, 1, 32'h0C, 4'hF, 0, 8'h77, 0);
    issue(1, 1, 32'h10, 4'hF, 0, 8'h78, 0);
    idle(1, 4);
    issue(1, 1, 32'h20, 4'hF, 0, 8'h50, 0);
    issue(1, 1, 32'h24, 4'hF, 0, 8'h51, 0);
    idle(0, 1);
    issue(1, 1, 32'h28, 4'hF, 0, 8'h52, 0, 1);
    chk("clear_gnt", last_gnt, 0);
    @(negedge clk_i);
    chk("valid_after_clear", r_valid_o, 0);
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 3; i++) issue(1, 1, 32'(i * 4 + 4), 4'hF, 0, 8'(8'h60 + i), 1);
    idle(1, 3);
    for (int i = 0; i < 400; i++) begin
      user_i = 1'($urandom);
      issue(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom & 32'hFFFF_F03C, 4'($urandom),
            $urandom, 8'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) == 0));
    end
    user_i = 0;
    idle(1, 4);
    issue(1, 1, 32'h8, 4'hF, 0, 8'h90, 0);
    issue(1, 1, 32'hC, 4'hF, 0, 8'h91, 0);
    rst_ni = 0;
    idle(0, 2);
    @(negedge clk_i);
    chk("valid_after_async_rst", {r_valid_o, gnt_o}, 0);
    rst_ni = 1;
    @(posedge clk_i);
    #1;
`ifdef HCI_BANK_RESPONDER_PERF_EN
    issue(0, 1, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) issue(1, 1, 32'(i * 4), 4'hF, 0, 8'(i), 0);
    @(negedge clk_i);
    chk("perf_counts", {perf_gnt_stall_o, perf_r_stall_o}, {32'd3, 32'd4});
    @(posedge clk_i);
    #1;
    idle(1, 4);
    @(negedge clk_i);
    force dut.perf_gnt_q = 32'hFFFF_FFFF;
    force dut.perf_r_q = 32'hFFFF_FFFF;
    @(posedge clk_i);
    #1;
    issue(1, 1, 32'h30, 4'hF, 0, 8'hA0, 0);
    release dut.perf_gnt_q;
    release dut.perf_r_q;
    for (int i = 0; i < 3; i++) issue(1, 1, 32'h34, 4'hF, 0, 8'(8'hA1 + i), 0);
    @(negedge clk_i);
    chk("perf_saturate", {perf_gnt_stall_o, perf_r_stall_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFF});
    @(posedge clk_i);
    #1;
    idle(1, 4);
`endif
    for (int i = 0; i < 4; i++) issue(1, 1, 32'(i * 4 + 64), 4'hF, 0, 8'(8'hB0 + i), 1);
    for (int i = 0; i < 50 && q.size() > 0; i++) idle(1, 1);
    @(negedge clk_i);
    chk("drain", {q.size(), r_valid_o}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
